// File: rtl/line_follow_pkg.sv
// Shared codes and constants for the line-follow motion controller.
// RAMP_STEP is only consumed when the RAMP_EN build macro is defined.
package line_follow_pkg;

    typedef enum logic [1:0] {
        TRK_STOP     = 2'b00,
        TRK_RIGHT    = 2'b01,
        TRK_LEFT     = 2'b10,
        TRK_STRAIGHT = 2'b11
    } track_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_BACKUP = 3'd2,
        ST_SEARCH = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic {
        TURN_RIGHT = 1'b0,
        TURN_LEFT  = 1'b1
    } turn_e;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam int unsigned RAMP_STEP = 64;

endpackage

// File: rtl/line_follow_motor_ctrl_wheel_pwm.sv
// One wheel channel: latches duty/direction at counter wrap and compares against the shared counter.
// Build macro RAMP_EN: slew applied duty by RAMP_STEP per period, passing through 0 on reversal.
module wheel_pwm
    import line_follow_pkg::*;
#(
    parameter int unsigned PWM_BITS = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] cnt,
    input  logic                wrap,
    input  logic [PWM_BITS:0]   tgt_duty,
    input  logic                tgt_fwd,
    output logic                pwm,
    output logic                fwd
);

    localparam int unsigned DUTY_W = PWM_BITS + 1;

    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              fwd_q, fwd_d;

`ifdef RAMP_EN
    int unsigned cur_i, tgt_i, ramp_i;
`endif

    // Next applied duty/direction, only allowed to move on the wrap cycle.
    always_comb begin
        duty_d = duty_q;
        fwd_d  = fwd_q;
`ifdef RAMP_EN
        cur_i  = 32'(duty_q);
        tgt_i  = 32'(tgt_duty);
        ramp_i = cur_i;
        if (wrap) begin
            if (fwd_q != tgt_fwd) begin
                if (cur_i == 0) begin
                    fwd_d = tgt_fwd;
                end else begin
                    ramp_i = (cur_i > RAMP_STEP) ? cur_i - RAMP_STEP : 0;
                end
            end else if (cur_i < tgt_i) begin
                ramp_i = ((tgt_i - cur_i) > RAMP_STEP) ? cur_i + RAMP_STEP : tgt_i;
            end else begin
                ramp_i = ((cur_i - tgt_i) > RAMP_STEP) ? cur_i - RAMP_STEP : tgt_i;
            end
            duty_d = DUTY_W'(ramp_i);
        end
`else
        if (wrap) begin
            duty_d = tgt_duty;
            fwd_d  = tgt_fwd;
        end
`endif
    end

    // Duty is one bit wider than the counter so a full-scale duty gives a constant high.
    always_ff @(posedge clk) begin
        if (reset) begin
            duty_q <= '0;
            fwd_q  <= DIR_FWD;
            pwm    <= 1'b0;
            fwd    <= DIR_FWD;
        end else begin
            duty_q <= duty_d;
            fwd_q  <= fwd_d;
            pwm    <= ({1'b0, cnt} < duty_q);
            fwd    <= fwd_q;
        end
    end

endmodule

// File: rtl/line_follow_motor_ctrl.sv
// Motion sequencer for the line-follow car: drive, lost-track backup/search/halt, shared PWM counter.
// Build macro RAMP_EN (in wheel_pwm) enables duty slewing.
module line_follow_motor_ctrl
    import line_follow_pkg::*;
#(
    parameter int unsigned PWM_BITS      = 10,
    parameter int unsigned SPEED_FAST    = 800,
    parameter int unsigned SPEED_SLOW    = 300,
    parameter int unsigned LOST_CYCLES   = 5_000_000,
    parameter int unsigned BACK_CYCLES   = 10_000_000,
    parameter int unsigned SEARCH_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] track_state,
    output logic       left_pwm,
    output logic       right_pwm,
    output logic       left_fwd,
    output logic       right_fwd,
    output logic [2:0] mode,
    output logic       halted
);

    localparam int unsigned DUTY_W   = PWM_BITS + 1;
    localparam int unsigned LOST_W   = $clog2(LOST_CYCLES + 1);
    localparam int unsigned BACK_W   = $clog2(BACK_CYCLES + 1);
    localparam int unsigned SEARCH_W = $clog2(SEARCH_CYCLES + 1);

    localparam logic [DUTY_W-1:0] DUTY_FAST = DUTY_W'(SPEED_FAST);
    localparam logic [DUTY_W-1:0] DUTY_SLOW = DUTY_W'(SPEED_SLOW);

    if (SPEED_FAST >= (1 << PWM_BITS) || SPEED_SLOW >= (1 << PWM_BITS)) begin : g_speed_check
        $error("SPEED_FAST and SPEED_SLOW must be below 2**PWM_BITS");
    end
    if (LOST_CYCLES == 0 || BACK_CYCLES == 0 || SEARCH_CYCLES == 0) begin : g_timer_check
        $error("cycle parameters must be non-zero");
    end

    state_e              state_q, state_d;
    turn_e               turn_q, turn_d;
    logic [LOST_W-1:0]   lost_q, lost_d;
    logic [BACK_W-1:0]   back_q, back_d;
    logic [SEARCH_W-1:0] search_q, search_d;
    logic [DUTY_W-1:0]   tgt_l_q, tgt_l_d, tgt_r_q, tgt_r_d;
    logic                tfwd_l_q, tfwd_l_d, tfwd_r_q, tfwd_r_d;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_wrap;

    assign pwm_wrap = (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            turn_q   <= TURN_RIGHT;
            lost_q   <= '0;
            back_q   <= '0;
            search_q <= '0;
            tgt_l_q  <= '0;
            tgt_r_q  <= '0;
            tfwd_l_q <= DIR_FWD;
            tfwd_r_q <= DIR_FWD;
            pwm_cnt  <= '0;
            mode     <= 3'd0;
            halted   <= 1'b0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            lost_q   <= lost_d;
            back_q   <= back_d;
            search_q <= search_d;
            tgt_l_q  <= tgt_l_d;
            tgt_r_q  <= tgt_r_d;
            tfwd_l_q <= tfwd_l_d;
            tfwd_r_q <= tfwd_r_d;
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            mode     <= 3'(state_q);
            halted   <= (state_q == ST_HALT);
        end
    end

    // Next state, timers and wheel targets; enable low overrides everything.
    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        lost_d   = lost_q;
        back_d   = back_q;
        search_d = search_q;
        tgt_l_d  = tgt_l_q;
        tgt_r_d  = tgt_r_q;
        tfwd_l_d = tfwd_l_q;
        tfwd_r_d = tfwd_r_q;

        unique case (state_q)
            ST_IDLE: begin
                tgt_l_d  = '0;
                tgt_r_d  = '0;
                tfwd_l_d = DIR_FWD;
                tfwd_r_d = DIR_FWD;
                if (enable) state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                lost_d = '0;
                case (track_e'(track_state))
                    TRK_STRAIGHT: begin
                        tgt_l_d  = DUTY_FAST;
                        tgt_r_d  = DUTY_FAST;
                        tfwd_l_d = DIR_FWD;
                        tfwd_r_d = DIR_FWD;
                    end
                    TRK_LEFT: begin
                        tgt_l_d  = DUTY_SLOW;
                        tgt_r_d  = DUTY_FAST;
                        tfwd_l_d = DIR_FWD;
                        tfwd_r_d = DIR_FWD;
                        turn_d   = TURN_LEFT;
                    end
                    TRK_RIGHT: begin
                        tgt_l_d  = DUTY_FAST;
                        tgt_r_d  = DUTY_SLOW;
                        tfwd_l_d = DIR_FWD;
                        tfwd_r_d = DIR_FWD;
                        turn_d   = TURN_RIGHT;
                    end
                    default: begin
                        // Line lost: keep the last targets while the loss timer runs.
                        if (lost_q == LOST_W'(LOST_CYCLES - 1)) state_d = ST_BACKUP;
                        else lost_d = lost_q + LOST_W'(1);
                    end
                endcase
            end
            ST_BACKUP: begin
                tgt_l_d  = DUTY_SLOW;
                tgt_r_d  = DUTY_SLOW;
                tfwd_l_d = DIR_REV;
                tfwd_r_d = DIR_REV;
                if (back_q == BACK_W'(BACK_CYCLES - 1)) begin
                    state_d = ST_SEARCH;
                    back_d  = '0;
                end else begin
                    back_d = back_q + BACK_W'(1);
                end
            end
            ST_SEARCH: begin
                tgt_l_d  = DUTY_SLOW;
                tgt_r_d  = DUTY_SLOW;
                tfwd_l_d = (turn_q == TURN_LEFT) ? DIR_REV : DIR_FWD;
                tfwd_r_d = (turn_q == TURN_LEFT) ? DIR_FWD : DIR_REV;
                if (track_state != TRK_STOP) begin
                    state_d  = ST_DRIVE;
                    search_d = '0;
                end else if (search_q == SEARCH_W'(SEARCH_CYCLES - 1)) begin
                    state_d  = ST_HALT;
                    search_d = '0;
                end else begin
                    search_d = search_q + SEARCH_W'(1);
                end
            end
            ST_HALT: begin
                tgt_l_d  = '0;
                tgt_r_d  = '0;
                tfwd_l_d = DIR_FWD;
                tfwd_r_d = DIR_FWD;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!enable) begin
            state_d  = ST_IDLE;
            lost_d   = '0;
            back_d   = '0;
            search_d = '0;
            tgt_l_d  = '0;
            tgt_r_d  = '0;
            tfwd_l_d = DIR_FWD;
            tfwd_r_d = DIR_FWD;
        end
    end

    wheel_pwm #(.PWM_BITS(PWM_BITS)) u_left (
        .clk      (clk),
        .reset    (reset),
        .cnt      (pwm_cnt),
        .wrap     (pwm_wrap),
        .tgt_duty (tgt_l_q),
        .tgt_fwd  (tfwd_l_q),
        .pwm      (left_pwm),
        .fwd      (left_fwd)
    );

    wheel_pwm #(.PWM_BITS(PWM_BITS)) u_right (
        .clk      (clk),
        .reset    (reset),
        .cnt      (pwm_cnt),
        .wrap     (pwm_wrap),
        .tgt_duty (tgt_r_q),
        .tgt_fwd  (tfwd_r_q),
        .pwm      (right_pwm),
        .fwd      (right_fwd)
    );

endmodule

// File: tb/tb_line_follow_motor_ctrl.sv
// Scoreboard bench for line_follow_motor_ctrl with a 16-cycle PWM period and short timers.
module tb_line_follow_motor_ctrl;

    localparam int unsigned PWM_BITS = 4;
    localparam int unsigned FAST     = 12;
    localparam int unsigned SLOW     = 5;
    localparam int unsigned LOST     = 8;
    localparam int unsigned BACK     = 40;
    localparam int unsigned SEARCH   = 40;
    localparam int unsigned PER      = 1 << PWM_BITS;
    localparam int unsigned BUDGET   = 300;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] track_state;
    logic       left_pwm, right_pwm, left_fwd, right_fwd, halted;
    logic [2:0] mode;

    int unsigned k;
    int          errors = 0;
    int          checks = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    line_follow_motor_ctrl #(
        .PWM_BITS      (PWM_BITS),
        .SPEED_FAST    (FAST),
        .SPEED_SLOW    (SLOW),
        .LOST_CYCLES   (LOST),
        .BACK_CYCLES   (BACK),
        .SEARCH_CYCLES (SEARCH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .track_state (track_state),
        .left_pwm    (left_pwm),
        .right_pwm   (right_pwm),
        .left_fwd    (left_fwd),
        .right_fwd   (right_fwd),
        .mode        (mode),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] val);
        tag_q.push_back(tag);
        exp_q.push_back(val);
    endtask

    task automatic pop_chk(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", got, 32'hFFFF_FFFF);
        end else begin
            check_eq(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    // One clock: active edge, then park on the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic wait_mode(input logic [2:0] target, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (mode != target && steps < BUDGET);
    endtask

    // Measure one full applied-duty period aligned to the counter wrap.
    task automatic expect_period(input string tag, input int hl_e, input int hr_e,
                                 input logic fl_e, input logic fr_e);
        int   hl, hr;
        logic fl, fr;
        push_exp({tag, "_left_high"}, hl_e);
        push_exp({tag, "_right_high"}, hr_e);
        push_exp({tag, "_left_fwd"}, 32'(fl_e));
        push_exp({tag, "_right_fwd"}, 32'(fr_e));
        while (k % PER != 0) step();
        hl = 0;
        hr = 0;
        fl = 1'bx;
        fr = 1'bx;
        for (int i = 0; i < int'(PER); i++) begin
            step();
            if (i == 0) begin
                fl = left_fwd;
                fr = right_fwd;
            end
            hl += int'(left_pwm);
            hr += int'(right_pwm);
        end
        pop_chk(hl);
        pop_chk(hr);
        pop_chk(32'(fl));
        pop_chk(32'(fr));
    endtask

    task automatic expect_reset_values(input string tag);
        push_exp({tag, "_left_pwm"}, 0);
        push_exp({tag, "_right_pwm"}, 0);
        push_exp({tag, "_left_fwd"}, 1);
        push_exp({tag, "_right_fwd"}, 1);
        push_exp({tag, "_mode"}, 0);
        push_exp({tag, "_halted"}, 0);
        pop_chk(32'(left_pwm));
        pop_chk(32'(right_pwm));
        pop_chk(32'(left_fwd));
        pop_chk(32'(right_fwd));
        pop_chk(32'(mode));
        pop_chk(32'(halted));
    endtask

    task automatic enter_backup();
        int steps;
        enable      = 1'b1;
        track_state = 2'b11;
        step();
        track_state = 2'b00;
        repeat (LOST) step();
        push_exp("enter_backup_steps", 1);
        wait_mode(3'd2, steps);
        pop_chk(steps);
    endtask

    initial begin
        int          steps, hl;
        int unsigned kb, ks;

        reset       = 1'b1;
        enable      = 1'b0;
        track_state = 2'b11;
        k           = 0;
        repeat (3) @(negedge clk);
        expect_reset_values("reset");

        // Straight ahead from IDLE.
        reset  = 1'b0;
        enable = 1'b1;
        k      = 0;
        step();
        step();
        expect_period("straight", FAST, FAST, 1'b1, 1'b1);
        push_exp("drive_mode", 1);
        pop_chk(32'(mode));

        // Turns take effect only from the following wrap.
        track_state = 2'b10;
        expect_period("left_pending", FAST, FAST, 1'b1, 1'b1);
        expect_period("turn_left", SLOW, FAST, 1'b1, 1'b1);
        track_state = 2'b01;
        expect_period("right_pending", SLOW, FAST, 1'b1, 1'b1);
        expect_period("turn_right", FAST, SLOW, 1'b1, 1'b1);

        // One cycle short of the loss limit keeps driving.
        track_state = 2'b00;
        repeat (LOST - 1) step();
        track_state = 2'b11;
        repeat (10) step();
        push_exp("lost_short_mode", 1);
        pop_chk(32'(mode));

        // Full loss: backup, then search pivoting right.
        track_state = 2'b00;
        repeat (LOST) step();
        push_exp("lost_backup_steps", 1);
        wait_mode(3'd2, steps);
        pop_chk(steps);
        kb = k;
        step();
        expect_period("backup", SLOW, SLOW, 1'b0, 1'b0);
        push_exp("backup_len", BACK);
        wait_mode(3'd3, steps);
        pop_chk(k - kb);
        ks = k;
        step();
        expect_period("search_right", SLOW, SLOW, 1'b1, 1'b0);

        track_state = 2'b01;
        push_exp("search_to_drive_steps", 2);
        wait_mode(3'd1, steps);
        pop_chk(steps);

        // Search timeout into HALT, then enable low back to IDLE.
        track_state = 2'b00;
        repeat (LOST) step();
        wait_mode(3'd2, steps);
        wait_mode(3'd3, steps);
        ks = k;
        push_exp("search_len", SEARCH);
        wait_mode(3'd4, steps);
        pop_chk(k - ks);
        push_exp("halted_set", 1);
        pop_chk(32'(halted));
        step();
        expect_period("halt", 0, 0, 1'b1, 1'b1);
        enable = 1'b0;
        push_exp("halt_to_idle_steps", 2);
        wait_mode(3'd0, steps);
        pop_chk(steps);
        push_exp("halted_clear", 0);
        pop_chk(32'(halted));

        // Enable dropped during BACKUP.
        enter_backup();
        repeat (20) step();
        enable = 1'b0;
        push_exp("backup_en0_steps", 2);
        wait_mode(3'd0, steps);
        pop_chk(steps);
        step();
        expect_period("idle_after_en0", 0, 0, 1'b1, 1'b1);

        // Reset asserted during BACKUP.
        enter_backup();
        repeat (20) step();
        reset = 1'b1;
        step();
        expect_reset_values("mid_reset");
        enable = 1'b0;
        reset  = 1'b0;
        k      = 0;
        push_exp("post_reset_pulses", 0);
        hl = 0;
        for (int i = 0; i < int'(2 * PER); i++) begin
            step();
            hl += int'(left_pwm) + int'(right_pwm);
        end
        pop_chk(hl);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
